// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller.
// Size encodings, FSM states and the size-to-byte-mask helper.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic {
        IDLE,
        SECOND
    } state_t;

    // Size 3 is treated as a word.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        unique case (size)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_shift.sv
// Byte-lane steering: low-word and high-word write masks and data
// for an access at byte offset off, plus the word-crossing flag.
module dmem_lane_shift
    import dmem_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic        split,
    output logic [3:0]  we_lo,
    output logic [3:0]  we_hi,
    output logic [31:0] din_lo,
    output logic [31:0] din_hi
);

    logic [7:0] wide;
    logic [5:0] hi_sh;

    // Bytes pushed past lane 3 land in the next word.
    assign wide   = {4'b0000, size_mask(size)} << off;
    assign we_lo  = wide[3:0];
    assign we_hi  = wide[7:4];
    assign split  = |wide[7:4];
    assign hi_sh  = 6'd32 - {1'b0, off, 3'b000};
    assign din_lo = data << {off, 3'b000};
    assign din_hi = data >> hi_sh;

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer for data-RAM port A; word-crossing accesses take two cycles.
// Define DMEM_ALIGN_TRAP_EN to trap on word-crossing accesses instead of splitting them.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              flush,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              misalign,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

`ifdef DMEM_ALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    state_t      state;
    logic        split;
    logic [3:0]  we_lo;
    logic [3:0]  we_hi;
    logic [31:0] din_lo;
    logic [31:0] din_hi;
    logic        go;
    logic        trap;

    logic        pend_split;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic [31:0] lo_buf;
    logic [31:0] merged;
    logic [31:0] mask32;
    logic [3:0]  m;

    logic [ADDR_W-3:0] word;
    logic [ADDR_W-3:0] word_nx;

    dmem_lane_shift u_lane (
        .off    (req_addr[1:0]),
        .size   (req_size),
        .data   (req_wdata),
        .split  (split),
        .we_lo  (we_lo),
        .we_hi  (we_hi),
        .din_lo (din_lo),
        .din_hi (din_hi)
    );

    assign go      = req_valid & ~flush;
    assign trap    = split & TRAP_EN;
    assign word    = req_addr[ADDR_W-1:2];
    assign word_nx = word + {{(ADDR_W-3){1'b0}}, 1'b1};

    // RAM port is driven in the request cycle; req_* is held through SECOND.
    always_comb begin
        stall    = 1'b0;
        ram_we   = 4'b0000;
        ram_addr = word;
        ram_din  = din_lo;
        if (rst) begin
            ram_addr = '0;
            ram_din  = '0;
        end else if (state == SECOND) begin
            ram_addr = word_nx;
            ram_din  = din_hi;
            ram_we   = req_store ? we_hi : 4'b0000;
        end else if (go && !trap) begin
            ram_we = req_store ? we_lo : 4'b0000;
            stall  = split;
        end
    end

    // Merge buffered low-word bytes with the high word arriving now.
    assign m      = size_mask(size_q);
    assign mask32 = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};

    always_comb begin
        merged = ram_dout >> {off_q, 3'b000};
        if (pend_split)
            merged = (lo_buf >> {off_q, 3'b000})
                   | (ram_dout << (6'd32 - {1'b0, off_q, 3'b000}));
    end

    assign rdata = rdata_valid ? (merged & mask32) : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rdata_valid <= 1'b0;
            misalign    <= 1'b0;
            pend_split  <= 1'b0;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            lo_buf      <= 32'h0;
        end else begin
            rdata_valid <= 1'b0;
            misalign    <= 1'b0;
            if (state == SECOND) begin
                state  <= IDLE;
                lo_buf <= ram_dout;
                if (!req_store) begin
                    rdata_valid <= 1'b1;
                    pend_split  <= 1'b1;
                end
            end else if (go) begin
                off_q  <= req_addr[1:0];
                size_q <= req_size;
                if (trap) begin
                    misalign <= 1'b1;
                end else if (split) begin
                    state <= SECOND;
                end else if (!req_store) begin
                    rdata_valid <= 1'b1;
                    pend_split  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl with a behavioural byte-enabled RAM.
// Build with +define+DMEM_ALIGN_TRAP_EN to exercise the trap configuration.
module tb_dmem_access_ctrl;

    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        flush = 1'b0;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misalign;
    logic [3:0]  ram_we;
    logic [29:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = 32'h0;

    dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_store   (req_store),
        .req_size    (req_size),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .flush       (flush),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .misalign    (misalign),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [31:0] mem [logic [29:0]];

    typedef struct {
        logic [31:0] d;
        int          c;
    } rd_t;

    typedef struct {
        logic [29:0] a;
        logic [3:0]  we;
        logic [31:0] d;
    } wr_t;

    rd_t rq[$];
    wr_t wq[$];
    int  mq[$];
    rd_t re;
    wr_t we_e;
    int  me;

    function automatic logic [31:0] lanes(input logic [3:0] we);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++)
            if (we[i]) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [31:0] rd_mem(input logic [29:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Synchronous RAM: read-before-write, one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ram_dout <= rd_mem(ram_addr);
        if (ram_we != 4'b0000)
            mem[ram_addr] = (rd_mem(ram_addr) & ~lanes(ram_we))
                          | (ram_din & lanes(ram_we));
    end

    // Monitor: pops expectations whenever the DUT presents a response.
    always @(negedge clk) begin
        if (!rst) begin
            if (rdata_valid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rdata_valid", rdata, 32'hxxxxxxxx);
                end else begin
                    re = rq.pop_front();
                    chk("rdata", rdata, re.d);
                    chk("rdata_cycle", cyc, re.c);
                end
            end
            if (ram_we != 4'b0000) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", {ram_addr, ram_we[1:0]}, 32'hxxxxxxxx);
                end else begin
                    we_e = wq.pop_front();
                    chk("ram_addr", {2'b00, ram_addr}, {2'b00, we_e.a});
                    chk("ram_we", {28'h0, ram_we}, {28'h0, we_e.we});
                    chk("ram_din", ram_din & lanes(ram_we), we_e.d & lanes(we_e.we));
                end
            end
            if (misalign) begin
                if (mq.size() == 0) begin
                    chk("unexpected_misalign", 32'h1, 32'h0);
                end else begin
                    me = mq.pop_front();
                    chk("misalign_cycle", cyc, me);
                end
            end
        end
    end

    task automatic push_wr(input logic [29:0] a, input logic [3:0] we, input logic [31:0] d);
        wq.push_back('{a, we, d});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 so calls chain back-to-back.
    // fmode: 0 none, 1 flush in first cycle, 2 flush in SECOND.
    task automatic acc(input bit st, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int fmode, input int exp_stall,
                       input bit want_rd, input logic [31:0] exp_rd);
        int ns;
        ns = 0;
        req_valid = 1'b1;
        req_store = st;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        flush     = (fmode == 1);
        if (want_rd) rq.push_back('{exp_rd, cyc + exp_stall + 1});
        @(negedge clk);
        if (stall) ns++;
        for (int k = 0; k < 3 && stall; k++) begin
            @(posedge clk);
            #1;
            flush = (fmode == 2);
            @(negedge clk);
            if (stall) ns++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        chk("stall_cycles", ns, exp_stall);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rdata_valid", {31'h0, rdata_valid}, 32'h0);
        chk("rst_misalign", {31'h0, misalign}, 32'h0);
        chk("rst_ram_we", {28'h0, ram_we}, 32'h0);
        chk("rst_ram_addr", {2'b00, ram_addr}, 32'h0);
        chk("rst_ram_din", ram_din, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Aligned store then load
        push_wr(30'h40, 4'hF, 32'hDEADBEEF);
        acc(1, 2'd2, 32'h100, 32'hDEADBEEF, 0, 0, 0, 32'h0);
        acc(0, 2'd2, 32'h100, 32'h0, 0, 0, 1, 32'hDEADBEEF);
        idle(2);
        chk("mem_40_sw", rd_mem(30'h40), 32'hDEADBEEF);

`ifndef DMEM_ALIGN_TRAP_EN
        // Split halfword store over zeroed RAM, then read back
        mem.delete();
        push_wr(30'h40, 4'b1000, 32'hB2000000);
        push_wr(30'h41, 4'b0001, 32'h000000A1);
        acc(1, 2'd1, 32'h103, 32'h0000A1B2, 0, 1, 0, 32'h0);
        acc(0, 2'd1, 32'h103, 32'h0, 0, 1, 1, 32'h0000A1B2);
        idle(2);
        chk("mem_40_sh", rd_mem(30'h40), 32'hB2000000);
        chk("mem_41_sh", rd_mem(30'h41), 32'h000000A1);

        // Loads of every size and offset over a known pair of words
        mem[30'h40] = 32'h44332211;
        mem[30'h41] = 32'h88776655;
        acc(0, 2'd2, 32'h102, 32'h0, 0, 1, 1, 32'h66554433);
        acc(0, 2'd0, 32'h101, 32'h0, 0, 0, 1, 32'h00000022);
        acc(0, 2'd1, 32'h102, 32'h0, 0, 0, 1, 32'h00004433);
        acc(0, 2'd1, 32'h101, 32'h0, 0, 0, 1, 32'h00003322);
        acc(0, 2'd3, 32'h100, 32'h0, 0, 0, 1, 32'h44332211);
        acc(0, 2'd1, 32'h103, 32'h0, 0, 1, 1, 32'h00005544);
        acc(0, 2'd2, 32'h101, 32'h0, 0, 1, 1, 32'h55443322);
        idle(2);

        // Flush in SECOND completes; flush in IDLE drops
        mem.delete();
        push_wr(30'h80, 4'b1110, 32'h22334400);
        push_wr(30'h81, 4'b0001, 32'h00000011);
        acc(1, 2'd2, 32'h201, 32'h11223344, 2, 1, 0, 32'h0);
        acc(1, 2'd2, 32'h300, 32'hCAFEF00D, 1, 0, 0, 32'h0);
        acc(0, 2'd2, 32'h200, 32'h0, 1, 0, 0, 32'h0);
        idle(2);
        chk("mem_80_flush2", rd_mem(30'h80), 32'h22334400);
        chk("mem_81_flush2", rd_mem(30'h81), 32'h00000011);
        chk("mem_C0_flush1", rd_mem(30'hC0), 32'h0);

        // Reset during SECOND of a split store
        mem.delete();
        mem[30'h101] = 32'h12345678;
        push_wr(30'h100, 4'b1100, 32'hCCDD0000);
        req_valid = 1'b1;
        req_store = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h402;
        req_wdata = 32'hAABBCCDD;
        @(negedge clk);
        chk("rst2_stall_first", {31'h0, stall}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_stall", {31'h0, stall}, 32'h0);
        chk("rst2_ram_we", {28'h0, ram_we}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        acc(0, 2'd2, 32'h404, 32'h0, 0, 0, 1, 32'h12345678);
        idle(2);
        chk("rst2_mem_101", rd_mem(30'h101), 32'h12345678);
        chk("rst2_mem_100", rd_mem(30'h100), 32'hCCDD0000);

        // Word address wraps from the top word to word 0
        mem.delete();
        push_wr(30'h3FFFFFFF, 4'b1100, 32'h77880000);
        push_wr(30'h0, 4'b0011, 32'h00005566);
        acc(1, 2'd2, 32'hFFFFFFFE, 32'h55667788, 0, 1, 0, 32'h0);
        acc(0, 2'd1, 32'hFFFFFFFF, 32'h0, 0, 1, 1, 32'h00006677);
        idle(2);
        chk("wrap_mem_0", rd_mem(30'h0), 32'h00005566);
        chk("wrap_mem_top", rd_mem(30'h3FFFFFFF), 32'h77880000);
`else
        // Trap build: split accesses raise misalign and do nothing else
        mem.delete();
        mq.push_back(cyc + 1);
        acc(0, 2'd2, 32'h101, 32'h0, 0, 0, 0, 32'h0);
        mq.push_back(cyc + 1);
        acc(1, 2'd1, 32'h103, 32'h0000A1B2, 0, 0, 0, 32'h0);
        push_wr(30'h40, 4'b1100, 32'hA1B20000);
        acc(1, 2'd1, 32'h102, 32'h0000A1B2, 0, 0, 0, 32'h0);
        acc(0, 2'd1, 32'h102, 32'h0, 0, 0, 1, 32'h0000A1B2);
        idle(2);
        chk("trap_mem_41", rd_mem(30'h41), 32'h0);
        chk("trap_mem_40", rd_mem(30'h40), 32'hA1B20000);
`endif

        idle(3);
        chk("rq_drained", rq.size(), 32'h0);
        chk("wq_drained", wq.size(), 32'h0);
        chk("mq_drained", mq.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
